// File: rtl/mm_sched_if.sv
// Bundle of requester-side and multiplier-side signals of the matrix-multiply
// job scheduler; the scheduler sits on the slave modport.
interface mm_sched_if #(
  parameter int W = 72
);
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         ack0;
  logic         ack1;
  logic         rsp_valid0;
  logic         rsp_valid1;
  logic         rsp_err;
  logic [W-1:0] rsp_c;
  logic         busy;
  logic         mm_reset;
  logic         mm_enable;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_c;
  logic         mm_done;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mm_c, mm_done,
    output ack0, ack1, rsp_valid0, rsp_valid1, rsp_err, rsp_c, busy,
           mm_reset, mm_enable, mm_a, mm_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mm_c, mm_done,
    input  ack0, ack1, rsp_valid0, rsp_valid1, rsp_err, rsp_c, busy,
           mm_reset, mm_enable, mm_a, mm_b
  );
endinterface

// File: rtl/mm_sched.sv
// Two-requester round-robin scheduler for a 3x3 matrix multiplier: grants a job,
// runs the multiplier with a timeout, and returns the result or an abort.
module mm_sched #(
  parameter int TIMEOUT = 64,
  parameter int W       = 72
) (
  input logic     clk,
  input logic     rst,
  mm_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1: current job belongs to requester 1
  logic          rr_q, rr_d;         // 1: requester 1 wins the next tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic          rsp_err_q, rsp_err_d;
  logic [W-1:0]  rsp_c_q, rsp_c_d;
  logic          mm_reset_q, mm_reset_d;
  logic          mm_enable_q, mm_enable_d;
  logic [W-1:0]  mm_a_q, mm_a_d, mm_b_q, mm_b_d;
  logic          grant;

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rsp_valid0 = rsp_valid0_q;
  assign bus.rsp_valid1 = rsp_valid1_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.mm_reset   = mm_reset_q;
  assign bus.mm_enable  = mm_enable_q;
  assign bus.mm_a       = mm_a_q;
  assign bus.mm_b       = mm_b_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    rsp_err_d    = rsp_err_q;
    rsp_c_d      = rsp_c_q;
    mm_reset_d   = mm_reset_q;
    mm_enable_d  = mm_enable_q;
    mm_a_d       = mm_a_q;
    mm_b_d       = mm_b_q;
    grant        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = (bus.req0 && bus.req1) ? rr_q : bus.req1;
          ack0_d     = ~grant;
          ack1_d     = grant;
          owner_d    = grant;
          rr_d       = ~grant;
          mm_a_d     = grant ? bus.a1 : bus.a0;
          mm_b_d     = grant ? bus.b1 : bus.b0;
          mm_reset_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        mm_reset_d  = 1'b0;
        mm_enable_d = 1'b1;
        cnt_d       = '0;
        state_d     = RUN;
      end
      RUN: begin
        // A completion on the final allowed cycle still counts as a good result.
        if (bus.mm_done) begin
          rsp_c_d      = bus.mm_c;
          rsp_valid0_d = ~owner_q;
          rsp_valid1_d = owner_q;
          rsp_err_d    = 1'b0;
          mm_enable_d  = 1'b0;
          state_d      = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_c_d      = '0;
          rsp_valid0_d = ~owner_q;
          rsp_valid1_d = owner_q;
          rsp_err_d    = 1'b1;
          mm_enable_d  = 1'b0;
          mm_reset_d   = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_err_d  = 1'b0;
        mm_reset_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_c_q      <= '0;
      mm_reset_q   <= 1'b1;
      mm_enable_q  <= 1'b0;
      mm_a_q       <= '0;
      mm_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_err_q    <= rsp_err_d;
      rsp_c_q      <= rsp_c_d;
      mm_reset_q   <= mm_reset_d;
      mm_enable_q  <= mm_enable_d;
      mm_a_q       <= mm_a_d;
      mm_b_q       <= mm_b_d;
    end
  end
endmodule

// File: doc/mm_sched.md
MM_SCHED -- requirements
Module: mm_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum RUN cycles to wait for mm_done before aborting a job.
REQ-002 Parameter W, default 72: operand/result bus width (nine 8-bit elements, 3x3 matrix).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  requester n job request; held high with operands stable until ack_n.
REQ-006 a0, b0, a1, b1  input  W each  requester n operand matrices A and B.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: job from requester n accepted, operands latched.
REQ-008 rsp_valid0, rsp_valid1  output  1 each  one-cycle pulse: result for requester n on rsp_c.
REQ-009 rsp_err  output  1  qualifies rsp_valid_n: job aborted by timeout.
REQ-010 rsp_c  output  W  result matrix C, held until next response.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mm_reset, mm_enable  output  1 each  drive multiplier reset and Enable.
REQ-013 mm_a, mm_b  output  W each  operands to multiplier.
REQ-014 mm_c  input  W; mm_done  input  1  multiplier result and completion flag.

Function
REQ-015 States: IDLE, LOAD, RUN, RESP; exactly one active.
REQ-016 IDLE with any req_n high: grant one, pulse ack_n, latch a_n/b_n into mm_a/mm_b, record owner, set mm_reset=1, go LOAD.
REQ-017 Arbitration round-robin: both requests high -> grant requester not granted last; after reset requester 0 wins first tie.
REQ-018 Single request high -> granted regardless of history; the round-robin pointer updates on every grant.
REQ-019 LOAD lasts exactly one cycle: next edge mm_reset=0, mm_enable=1, timeout counter=0, go RUN.
REQ-020 RUN, mm_done=1: rsp_c<=mm_c, rsp_valid_owner=1, rsp_err=0, mm_enable=0, go RESP.
REQ-021 RUN, mm_done=0: counter increments; when counter reaches TIMEOUT-1 with no mm_done: rsp_c<=0, rsp_valid_owner=1, rsp_err=1, mm_enable=0, mm_reset=1, go RESP.
REQ-022 mm_done and timeout on same edge: mm_done wins, normal result.
REQ-023 mm_done sampled in IDLE, LOAD or RESP is ignored.
REQ-024 RESP lasts one cycle: clear rsp_valid_n, rsp_err, mm_reset; go IDLE; no request accepted in RESP.
REQ-025 Minimum latency: req sampled at edge k -> ack at k, mm_enable at k+1, response earliest at k+2 (mm_done in first RUN cycle).
REQ-026 Back-to-back: earliest next ack at edge k+4 of previous sequence (IDLE re-entered after RESP).
REQ-027 Request dropped before ack: not granted, no state change; request dropped after ack: job still completes and responds.
REQ-028 At most one of ack0/ack1 and one of rsp_valid0/rsp_valid1 high in any cycle.
REQ-029 Counter width ceil(log2(TIMEOUT))+1 bits; no wrap possible before abort.

Reset
REQ-030 rst high immediately forces: state IDLE, ack0/ack1=0, rsp_valid0/1=0, rsp_err=0, rsp_c=0, busy=0, mm_enable=0, mm_reset=1, mm_a=mm_b=0, counter=0, round-robin pointer to favour requester 0.
REQ-031 Reset mid-job (LOAD/RUN/RESP) discards the job with no response pulse; after release, first edge deasserts mm_reset only via a new grant path (mm_reset stays 1 in IDLE until first LOAD completes).
REQ-032 Outputs stay at reset values while rst is high regardless of req_n or mm_done.

Verification
REQ-033 req0=1, A=identity, B=elements 1..9; model asserts mm_done 3 cycles after mm_enable -> ack0 at edge k, rsp_valid0 at k+4, rsp_c=B, rsp_err=0.
REQ-034 req0 and req1 both high from reset, held -> grants 0,1,0,1 alternate; each rsp_valid_n matches its own ack_n order.
REQ-035 Only req1 high for three jobs -> three grants to requester 1, then simultaneous request -> requester 0 granted.
REQ-036 TIMEOUT=8, mm_done never asserted -> rsp_valid_owner with rsp_err=1, rsp_c=0 after 8 RUN cycles; mm_reset high one cycle; busy falls next edge.
REQ-037 rst asserted during RUN, then mm_done pulse -> no rsp_valid, all outputs at reset values; next req accepted normally.
REQ-038 mm_done on exact timeout edge -> rsp_err=0, rsp_c=mm_c.
